// File: rtl/scpad_pkg.sv
// Shared scratchpad types: crossbar read descriptor and realigned response record.
package scpad_pkg;

  localparam int NUM_COLS      = 16;
  localparam int ELEM_WIDTH    = 16;
  localparam int ROW_IDX_WIDTH = 8;
  localparam int COL_IDX_WIDTH = $clog2(NUM_COLS);

  typedef struct packed {
    logic [NUM_COLS-1:0]                    valid_mask;
    logic [NUM_COLS-1:0][COL_IDX_WIDTH-1:0] shift_mask;
    logic [NUM_COLS-1:0][ROW_IDX_WIDTH-1:0] slot_mask;
  } xbar_desc_t;

  typedef struct packed {
    logic [NUM_COLS-1:0][ELEM_WIDTH-1:0] data;
    logic [NUM_COLS-1:0]                 mask;
  } unswizzle_resp_t;

  // Word seen on logical lane `lane` for descriptor d and raw bank data.
  function automatic logic [ELEM_WIDTH-1:0] lane_pick(
    input xbar_desc_t                          d,
    input logic [NUM_COLS-1:0][ELEM_WIDTH-1:0] rdata,
    input int                                  lane
  );
    if (d.valid_mask[lane]) begin
      return rdata[d.shift_mask[lane]];
    end else begin
      return '0;
    end
  endfunction

endpackage

// File: rtl/unswizzle_if.sv
// Bundle of the unswizzle ports, with a design-side and a bench-side view.
interface unswizzle_if (
  input logic clk
);
  logic                                                        rst;
  logic                                                        desc_valid;
  logic                                                        desc_ready;
  scpad_pkg::xbar_desc_t                                       desc;
  logic                                                        bank_rvalid;
  logic [scpad_pkg::NUM_COLS-1:0][scpad_pkg::ELEM_WIDTH-1:0]   bank_rdata;
  logic                                                        out_valid;
  logic                                                        out_ready;
  logic [scpad_pkg::NUM_COLS-1:0][scpad_pkg::ELEM_WIDTH-1:0]   out_data;
  logic [scpad_pkg::NUM_COLS-1:0]                              out_mask;
  logic                                                        err_orphan;

  modport unswizzle (
    input  clk, rst, desc_valid, desc, bank_rvalid, bank_rdata, out_ready,
    output desc_ready, out_valid, out_data, out_mask, err_orphan
  );

  modport tb (
    input  clk, desc_ready, out_valid, out_data, out_mask, err_orphan,
    output rst, desc_valid, desc, bank_rvalid, bank_rdata, out_ready
  );
endinterface

// File: rtl/scpad_fifo.sv
// Generic synchronous FIFO; occupancy counter separates full from empty,
// head word is read straight out of the storage registers.
module scpad_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        do_push_s;
  logic                        do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == CNT_W'(0));
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/unswizzle.sv
// Pairs bank read returns with the oldest outstanding crossbar descriptor and
// undoes the bank permutation into logical lane order, with credit flow control.
module unswizzle #(
  parameter int NUM_COLS   = scpad_pkg::NUM_COLS,
  parameter int ELEM_WIDTH = scpad_pkg::ELEM_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 desc_valid,
  output logic                                 desc_ready,
  input  scpad_pkg::xbar_desc_t                desc,
  input  logic                                 bank_rvalid,
  input  logic [NUM_COLS-1:0][ELEM_WIDTH-1:0]  bank_rdata,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_COLS-1:0][ELEM_WIDTH-1:0]  out_data,
  output logic [NUM_COLS-1:0]                  out_mask,
  output logic                                 err_orphan
);

  import scpad_pkg::*;

  localparam int CRED_W = $clog2(DEPTH) + 1;
  localparam int DESC_W = $bits(xbar_desc_t);
  localparam int RESP_W = $bits(unswizzle_resp_t);

  logic [CRED_W-1:0] credits_q, credits_d;
  logic              desc_ready_q, desc_ready_d;
  logic              err_orphan_q, err_orphan_d;

  logic              desc_accept_s;
  logic              ret_match_s;
  logic              orphan_s;
  logic              out_pop_s;

  xbar_desc_t        head_desc_s;
  logic              desc_full_s, desc_empty_s;
  logic [CRED_W-1:0] desc_count_s;

  unswizzle_resp_t   resp_in_s;
  unswizzle_resp_t   resp_head_s;
  logic              resp_full_s, resp_empty_s;
  logic [CRED_W-1:0] resp_count_s;

  // slot_mask and the FIFO occupancies are carried for debug visibility only.
  logic              unused_dbg_s;
  assign unused_dbg_s = ^{head_desc_s.slot_mask, desc_count_s, resp_count_s, desc_full_s};

  assign desc_accept_s = desc_valid && desc_ready_q;
  // A descriptor pushed this cycle is not visible through desc_empty_s yet.
  assign ret_match_s   = bank_rvalid && !desc_empty_s;
  assign orphan_s      = bank_rvalid && desc_empty_s;
  assign out_pop_s     = out_valid && out_ready;

  scpad_fifo #(.WIDTH(DESC_W), .DEPTH(DEPTH)) u_desc_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (desc_accept_s),
    .wdata (desc),
    .pop   (ret_match_s),
    .rdata (head_desc_s),
    .full  (desc_full_s),
    .empty (desc_empty_s),
    .count (desc_count_s)
  );

  always_comb begin
    resp_in_s      = '0;
    resp_in_s.mask = head_desc_s.valid_mask;
    for (int i = 0; i < NUM_COLS; i++) begin
      resp_in_s.data[i] = lane_pick(head_desc_s, bank_rdata, i);
    end
  end

  scpad_fifo #(.WIDTH(RESP_W), .DEPTH(DEPTH)) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_match_s && !resp_full_s),
    .wdata (resp_in_s),
    .pop   (out_pop_s),
    .rdata (resp_head_s),
    .full  (resp_full_s),
    .empty (resp_empty_s),
    .count (resp_count_s)
  );

  assign out_valid  = !resp_empty_s;
  assign out_data   = resp_head_s.data;
  assign out_mask   = resp_head_s.mask;
  assign desc_ready = desc_ready_q;
  assign err_orphan = err_orphan_q;

  always_comb begin
    credits_d = credits_q;
    case ({desc_accept_s, out_pop_s})
      2'b10:   credits_d = credits_q + CRED_W'(1);
      2'b01:   credits_d = credits_q - CRED_W'(1);
      default: credits_d = credits_q;
    endcase
    desc_ready_d = (credits_d < CRED_W'(DEPTH));
    err_orphan_d = err_orphan_q | orphan_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q    <= '0;
      desc_ready_q <= 1'b1;
      err_orphan_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      desc_ready_q <= desc_ready_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule

// File: tb/tb_unswizzle.sv
// Directed bench for unswizzle: realignment, credits, ordering, orphans, reset.
module tb_unswizzle;
  import scpad_pkg::*;

  localparam int DEPTH = 4;
  typedef logic [NUM_COLS-1:0][ELEM_WIDTH-1:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  unswizzle_if bus (.clk(clk));

  unswizzle #(.NUM_COLS(NUM_COLS), .ELEM_WIDTH(ELEM_WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (bus.rst),
    .desc_valid  (bus.desc_valid),
    .desc_ready  (bus.desc_ready),
    .desc        (bus.desc),
    .bank_rvalid (bus.bank_rvalid),
    .bank_rdata  (bus.bank_rdata),
    .out_valid   (bus.out_valid),
    .out_ready   (bus.out_ready),
    .out_data    (bus.out_data),
    .out_mask    (bus.out_mask),
    .err_orphan  (bus.err_orphan)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic xbar_desc_t mk_desc(input logic [15:0] vm, input int x);
    xbar_desc_t d;
    d.valid_mask = vm;
    for (int i = 0; i < NUM_COLS; i++) begin
      d.shift_mask[i] = COL_IDX_WIDTH'(i ^ x);
      d.slot_mask[i]  = ROW_IDX_WIDTH'(i);
    end
    return d;
  endfunction

  function automatic vec_t banks(input int base);
    vec_t v;
    for (int b = 0; b < NUM_COLS; b++) v[b] = ELEM_WIDTH'(base + b);
    return v;
  endfunction

  // Bank b holds base+b and lane i reads bank i^x, so lane i sees base+(i^x).
  function automatic vec_t exp_vec(input logic [15:0] vm, input int x, input int base);
    vec_t v;
    for (int i = 0; i < NUM_COLS; i++) v[i] = vm[i] ? ELEM_WIDTH'(base + (i ^ x)) : 16'h0000;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.desc_valid  = 1'b0;
    bus.bank_rvalid = 1'b0;
    bus.out_ready   = 1'b0;
  endtask

  vec_t v;

  initial begin
    bus.rst        = 1'b1;
    bus.desc       = '0;
    bus.bank_rdata = '0;
    idle();
    step();
    step();
    check("rst_desc_ready", bus.desc_ready, 1'b1);
    check("rst_out_valid",  bus.out_valid,  1'b0);
    check("rst_out_data",   bus.out_data,   256'h0);
    check("rst_out_mask",   bus.out_mask,   16'h0000);
    check("rst_err_orphan", bus.err_orphan, 1'b0);
    bus.rst = 1'b0;
    step();

    // Row read, shift i^5, all lanes valid.
    bus.desc_valid = 1'b1;
    bus.desc       = mk_desc(16'hffff, 5);
    step();
    bus.desc_valid  = 1'b0;
    bus.bank_rvalid = 1'b1;
    bus.bank_rdata  = banks(0);
    check("row_not_yet_valid", bus.out_valid, 1'b0);
    step();
    bus.bank_rvalid = 1'b0;
    check("row_out_valid", bus.out_valid, 1'b1);
    check("row_out_data",  bus.out_data,  exp_vec(16'hffff, 5, 0));
    check("row_out_mask",  bus.out_mask,  16'hffff);
    v = bus.out_data;
    check("row_lane0", v[0], 16'h0005);
    check("row_lane7", v[7], 16'h0002);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("row_drained", bus.out_valid, 1'b0);
    check("row_credit_back", bus.desc_ready, 1'b1);

    // Column read, lower 8 lanes valid, shift 3^i.
    bus.desc_valid = 1'b1;
    bus.desc       = mk_desc(16'h00ff, 3);
    step();
    bus.desc_valid  = 1'b0;
    bus.bank_rvalid = 1'b1;
    bus.bank_rdata  = banks(16'h100);
    step();
    bus.bank_rvalid = 1'b0;
    check("col_out_data", bus.out_data, exp_vec(16'h00ff, 3, 16'h100));
    check("col_out_mask", bus.out_mask, 16'h00ff);
    v = bus.out_data;
    check("col_lane0", v[0], 16'h0103);
    check("col_lane8", v[8], 16'h0000);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Backpressure fill: four reads, returns lag by one cycle, consumer stalled.
    for (int k = 0; k < 5; k++) begin
      bus.desc_valid  = (k < 4);
      bus.desc        = mk_desc(16'hffff, k + 1);
      bus.bank_rvalid = (k > 0);
      bus.bank_rdata  = banks(16'h200 + 16 * (k - 1));
      step();
      if (k == 2) check("bp_ready_at_3", bus.desc_ready, 1'b1);
      if (k == 3) check("bp_ready_at_4", bus.desc_ready, 1'b0);
    end
    idle();
    step();
    check("bp_hold_valid", bus.out_valid, 1'b1);
    check("bp_hold_data",  bus.out_data,  exp_vec(16'hffff, 1, 16'h200));
    check("bp_still_full", bus.desc_ready, 1'b0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_valid_%0d", k), bus.out_valid, 1'b1);
      check($sformatf("bp_data_%0d", k), bus.out_data, exp_vec(16'hffff, k + 1, 16'h200 + 16 * k));
      step();
      if (k == 0) check("bp_ready_after_pop", bus.desc_ready, 1'b1);
    end
    bus.out_ready = 1'b0;
    check("bp_empty", bus.out_valid, 1'b0);

    // Simultaneous accept, return and pop with two credits held.
    bus.desc_valid = 1'b1;
    bus.desc       = mk_desc(16'hffff, 6);
    step();
    bus.desc            = mk_desc(16'hffff, 7);
    bus.bank_rvalid     = 1'b1;
    bus.bank_rdata      = banks(16'h300);
    step();
    bus.desc            = mk_desc(16'h0f0f, 8);
    bus.bank_rdata      = banks(16'h310);
    bus.out_ready       = 1'b1;
    check("sim_head_a", bus.out_data, exp_vec(16'hffff, 6, 16'h300));
    step();
    check("sim_head_b", bus.out_data, exp_vec(16'hffff, 7, 16'h310));
    bus.out_ready  = 1'b0;
    bus.desc       = mk_desc(16'hf00f, 9);
    bus.bank_rdata = banks(16'h320);
    step();
    check("sim_ready_at_3", bus.desc_ready, 1'b1);
    bus.bank_rvalid = 1'b0;
    bus.desc        = mk_desc(16'hffff, 10);
    step();
    check("sim_ready_at_4", bus.desc_ready, 1'b0);
    bus.desc_valid  = 1'b0;
    bus.out_ready   = 1'b1;
    bus.bank_rvalid = 1'b1;
    bus.bank_rdata  = banks(16'h330);
    check("sim_order_b", bus.out_data, exp_vec(16'hffff, 7, 16'h310));
    step();
    bus.bank_rdata = banks(16'h340);
    check("sim_order_c", bus.out_data, exp_vec(16'h0f0f, 8, 16'h320));
    check("sim_mask_c",  bus.out_mask, 16'h0f0f);
    step();
    bus.bank_rvalid = 1'b0;
    check("sim_order_d", bus.out_data, exp_vec(16'hf00f, 9, 16'h330));
    step();
    check("sim_order_e", bus.out_data, exp_vec(16'hffff, 10, 16'h340));
    step();
    idle();
    check("sim_empty", bus.out_valid, 1'b0);
    check("sim_credits_free", bus.desc_ready, 1'b1);
    check("sim_no_orphan", bus.err_orphan, 1'b0);

    // Orphan return with nothing outstanding.
    bus.bank_rvalid = 1'b1;
    bus.bank_rdata  = banks(16'h400);
    step();
    bus.bank_rvalid = 1'b0;
    check("orph_flag", bus.err_orphan, 1'b1);
    check("orph_no_valid", bus.out_valid, 1'b0);
    step();
    step();
    step();
    check("orph_sticky", bus.err_orphan, 1'b1);

    // Reset while two descriptors are outstanding and one vector is buffered.
    bus.desc_valid = 1'b1;
    bus.desc       = mk_desc(16'hffff, 11);
    step();
    bus.desc        = mk_desc(16'hffff, 12);
    bus.bank_rvalid = 1'b1;
    bus.bank_rdata  = banks(16'h500);
    step();
    bus.desc        = mk_desc(16'hffff, 13);
    bus.bank_rvalid = 1'b0;
    step();
    bus.desc_valid = 1'b0;
    check("mid_buffered", bus.out_valid, 1'b1);
    #1;
    bus.rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_ready", bus.desc_ready, 1'b1);
    check("mid_rst_orphan_clr", bus.err_orphan, 1'b0);
    bus.rst = 1'b0;
    step();
    bus.bank_rvalid = 1'b1;
    bus.bank_rdata  = banks(16'h510);
    step();
    bus.bank_rvalid = 1'b0;
    check("mid_late_orphan", bus.err_orphan, 1'b1);
    check("mid_late_no_valid", bus.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
